branch_ctrl: RTL
================

# branch_ctrl

Multi-cycle branch resolution controller for the RV32I core. It accepts one conditional branch per handshake and evaluates the condition through its own comparator sub-module. It computes the target and checks the outcome against fetch's static prediction. It then either retires the branch or issues a redirect/flush to fetch, and it keeps branch and mispredict statistics.

## Interface
- XLEN, 32, operand/PC width
- CNT_W, 32, width of statistics counters
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  branch request valid
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_pc  in  XLEN  PC of branch instruction
- req_imm  in  XLEN  sign-extended B-type offset
- req_rs1, req_rs2  in  XLEN  source operands
- req_funct3  in  3  branch type
- req_pred_taken  in  1  fetch's prediction
- kill  in  1  abort the in-flight branch (younger-flush from elsewhere)
- res_valid  out  1  one-cycle pulse: branch resolved without exception
- res_taken  out  1  resolved direction, qualified by res_valid
- redir_valid  out  1  redirect request to fetch
- redir_ready  in  1  fetch accepts redirect
- redir_pc  out  XLEN  correct next PC, stable while redir_valid
- flush  out  1  equals redir_valid & redir_ready
- exc_valid  out  1  exception report valid
- exc_ready  in  1  exception consumer accepts
- exc_cause  out  2  1 = illegal funct3, 2 = misaligned target
- exc_pc  out  XLEN  PC of the faulting branch
- br_cnt  out  CNT_W  branches resolved
- mispred_cnt  out  CNT_W  mispredicted branches

## Operation
- Supported funct3 values: 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU. 010 and 011 are illegal.
- State IDLE: req_ready=1. When req_valid is high, capture all req_* fields into registers and go to EVAL.
- State EVAL (exactly 1 cycle):
  - taken = cmp(rs1, rs2, funct3).
  - target = pc + imm, 32-bit wrap-around with carry discarded.
  - fallthrough = pc + 4, also wrapping.
  - next_pc = taken ? target : fallthrough.
- EVAL exit, in priority order:
  1. Illegal funct3 → EXC, cause 1.
  2. taken && target[1:0] != 0 → EXC, cause 2.
  3. taken != pred_taken → REDIR, with redir_pc = next_pc.
  4. Otherwise → IDLE.
- When EVAL exits through rule 3 or 4, res_valid pulses high for that cycle. br_cnt increments; mispred_cnt also increments on rule 3. Both counters wrap at 2^CNT_W.
- A not-taken branch with a misaligned target is not an exception.
- State REDIR: redir_valid=1 and redir_pc is held. On redir_ready, flush=1 for that cycle and the next state is IDLE.
- State EXC: exc_valid=1 with exc_cause and exc_pc held. On exc_ready, next state is IDLE. Counters do not change.
- kill in EVAL, REDIR or EXC: next state is IDLE. No res_valid, no counter update, and no flush is produced that cycle even if redir_ready is high. kill in IDLE masks acceptance, so no request is captured.
- Priority: rst > kill > normal transitions.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: req_ready=1 on the first cycle after reset; res_valid, res_taken, redir_valid, flush and exc_valid = 0.
  - Buses: redir_pc, exc_pc and exc_cause = 0.
  - Counters: 0.
- Request accepted at cycle N; EVAL runs at N+1.
  - Correct prediction: res_valid at N+1, req_ready high again at N+2.
  - Mispredict: redir_valid is first high at N+2. If redir_ready is already high, flush is at N+2 and req_ready is high at N+3.
- Minimum throughput: one branch per 2 cycles.
- All outputs are registered or decoded from state only. None depends combinationally on req_*.
- redir_valid/exc_valid, once asserted, stay high with stable payload until accepted, kill, or rst.
- rst asserted mid-REDIR: redir_valid is low in the next cycle and no flush occurs.

## Structure
- branch_pkg holds:
  - funct3 localparams (F3_BEQ…F3_BGEU)
  - state enum {IDLE, EVAL, REDIR, EXC}
  - exc cause constants EXC_ILLEGAL=2'd1, EXC_MISALIGN=2'd2
- One sub-module, branch_cmp: combinational; inputs rs1, rs2, funct3; outputs taken and illegal. It is instantiated once on the registered operands.
- The target adders and counters live in branch_ctrl.

## Test plan
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred=1 → res_valid/res_taken=1 at N+1; no redirect; br_cnt=1, mispred_cnt=0.
- BLT, rs1=0xFFFFFFFF, rs2=1, pred=0, pc=0x200, imm=0xFFFFFFF0 → redir_pc=0x1F0, flush with redir_ready. Hold redir_ready low for 3 cycles first to check that redir_pc stays stable. mispred_cnt=1.
- BGEU, rs1=0xFFFFFFFF, rs2=1, pred=1, pc=0xFFFFFFFC, imm=8 → taken, target wraps to 0x4, no redirect.
- funct3=010 → exc_valid, exc_cause=1, exc_pc=req_pc, counters unchanged. BNE taken with imm=0x2 → exc_cause=2. Same BNE with rs1=rs2 → no exception, retires.
- Mispredict followed by kill while redir_valid is high and redir_ready=1 → no flush, IDLE next cycle, req_ready=1.
- rst asserted during EXC, and rst asserted in the same cycle as req_valid → all outputs at reset values next cycle, request not captured.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution controller.
//   - funct3 encodings of the RV32I conditional branches
//   - controller state enumeration
//   - exception cause codes reported on exc_cause
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        REDIR = 2'd2,
        EXC   = 2'd3
    } state_t;

    localparam logic [1:0] EXC_ILLEGAL  = 2'd1;
    localparam logic [1:0] EXC_MISALIGN = 2'd2;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator.
// Ports:
//   rs1, rs2  in   source operands
//   funct3    in   branch type
//   taken     out  condition result (0 when funct3 is illegal)
//   illegal   out  funct3 is not a conditional branch encoding
module branch_cmp
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Multi-cycle branch resolution controller.
// Accepts one branch in IDLE, resolves it in EVAL, then retires it, raises a
// redirect to fetch (REDIR) or reports an exception (EXC).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    branch request handshake and operands
//   kill                     abort the in-flight branch / mask acceptance
//   res_valid, res_taken     one-cycle retirement pulse and direction
//   redir_valid/ready/pc     redirect handshake to fetch
//   flush                    redirect accepted this cycle
//   exc_valid/ready/cause/pc exception report handshake
//   br_cnt, mispred_cnt      resolved / mispredicted branch counters
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_pc,
    input  logic [XLEN-1:0]  req_imm,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [2:0]       req_funct3,
    input  logic             req_pred_taken,
    input  logic             kill,
    output logic             res_valid,
    output logic             res_taken,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [XLEN-1:0]  redir_pc,
    output logic             flush,
    output logic             exc_valid,
    input  logic             exc_ready,
    output logic [1:0]       exc_cause,
    output logic [XLEN-1:0]  exc_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    state_t           state;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  imm_q;
    logic [XLEN-1:0]  rs1_q;
    logic [XLEN-1:0]  rs2_q;
    logic [2:0]       funct3_q;
    logic             pred_q;

    logic             taken;
    logic             illegal;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  fallthrough;
    logic [XLEN-1:0]  next_pc;
    logic             misalign;
    logic             retire;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .rs1     (rs1_q),
        .rs2     (rs2_q),
        .funct3  (funct3_q),
        .taken   (taken),
        .illegal (illegal)
    );

    always_comb begin
        target      = pc_q + imm_q;
        fallthrough = pc_q + XLEN'(4);
        next_pc     = taken ? target : fallthrough;
        // Only a taken branch can fault on its target alignment.
        misalign    = taken && (target[1:0] != 2'b00);
        retire      = (state == EVAL) && !illegal && !misalign && !kill && !rst;
    end

    // Handshake outputs decode from state; the result pulse and flush are
    // additionally masked so that a kill or reset in the same cycle
    // suppresses them.
    assign req_ready   = (state == IDLE);
    assign redir_valid = (state == REDIR);
    assign exc_valid   = (state == EXC);
    assign res_valid   = retire;
    assign res_taken   = retire && taken;
    assign flush       = redir_valid && redir_ready && !kill && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            funct3_q    <= '0;
            pred_q      <= 1'b0;
            redir_pc    <= '0;
            exc_cause   <= '0;
            exc_pc      <= '0;
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else if (kill) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        pc_q     <= req_pc;
                        imm_q    <= req_imm;
                        rs1_q    <= req_rs1;
                        rs2_q    <= req_rs2;
                        funct3_q <= req_funct3;
                        pred_q   <= req_pred_taken;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    if (illegal) begin
                        exc_cause <= EXC_ILLEGAL;
                        exc_pc    <= pc_q;
                        state     <= EXC;
                    end else if (misalign) begin
                        exc_cause <= EXC_MISALIGN;
                        exc_pc    <= pc_q;
                        state     <= EXC;
                    end else begin
                        br_cnt <= br_cnt + CNT_W'(1);
                        if (taken != pred_q) begin
                            mispred_cnt <= mispred_cnt + CNT_W'(1);
                            redir_pc    <= next_pc;
                            state       <= REDIR;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                REDIR: begin
                    if (redir_ready) state <= IDLE;
                end
                EXC: begin
                    if (exc_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
